// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Instruction decode stage for an RV64I-style pipeline. It decodes the
// instruction presented by fetch, reads the integer register file (with a
// bypass from the same-cycle writeback), builds the sign-extended immediate
// and registers the result into the decode->execute pipeline register.
//
// A load in the decode->execute register whose destination is needed by the
// instruction currently being decoded raises stall_o. Fetch then holds PC and
// instruction while this stage inserts a bubble. A redirect from execute
// (branchtaken) flushes the pipeline register and overrides any stall.
//
// Ports
//   clk_i               single clock, rising edge
//   reset_i             synchronous active-high reset
//   InstructionMem_out  instruction from fetch (32 bits)
//   pc_i                PC of InstructionMem_out
//   branchtaken         redirect from execute, flushes the output register
//   wb_we_i / wb_rd_i / wb_data_i   register file writeback port
//   stall_o             combinational load-use hold request to fetch
//   valid_o .. funct7b5_o            registered decode->execute payload
//   reg_we_o .. illegal_o            registered control bits
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [31:0]     InstructionMem_out,
    input  logic [XLEN-1:0] pc_i,
    input  logic            branchtaken,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      funct3_o,
    output logic            funct7b5_o,
    output logic            reg_we_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            branch_o,
    output logic            jal_o,
    output logic            jalr_o,
    output logic            alu_src_imm_o,
    output logic            lui_o,
    output logic            auipc_o,
    output logic            word_op_o,
    output logic            illegal_o
);

    // ------------------------------------------------------------------
    // Opcode encodings
    // ------------------------------------------------------------------
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;

    assign instr  = InstructionMem_out;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    logic is_load, is_store, is_branch, is_op_imm, is_op;
    logic is_op_imm32, is_op32, is_lui, is_auipc, is_jal, is_jalr;
    logic is_legal;

    assign is_load     = (opcode == OPC_LOAD);
    assign is_store    = (opcode == OPC_STORE);
    assign is_branch   = (opcode == OPC_BRANCH);
    assign is_op_imm   = (opcode == OPC_OP_IMM);
    assign is_op       = (opcode == OPC_OP);
    assign is_op_imm32 = (opcode == OPC_OP_IMM32);
    assign is_op32     = (opcode == OPC_OP32);
    assign is_lui      = (opcode == OPC_LUI);
    assign is_auipc    = (opcode == OPC_AUIPC);
    assign is_jal      = (opcode == OPC_JAL);
    assign is_jalr     = (opcode == OPC_JALR);

    assign is_legal = is_load | is_store | is_branch | is_op_imm | is_op |
                      is_op_imm32 | is_op32 | is_lui | is_auipc | is_jal | is_jalr;

    // ------------------------------------------------------------------
    // Register file (x0 is never written and always reads as zero)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we_i && (wb_rd_i != 5'd0)) begin
            regs[wb_rd_i] <= wb_data_i;
        end
    end

    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;

    // Writeback in the same cycle is forwarded so decode never sees stale data.
    always_comb begin
        rs1_rdata = '0;
        if (rs1 != 5'd0) begin
            if (wb_we_i && (wb_rd_i == rs1)) begin
                rs1_rdata = wb_data_i;
            end else begin
                rs1_rdata = regs[rs1];
            end
        end
    end

    always_comb begin
        rs2_rdata = '0;
        if (rs2 != 5'd0) begin
            if (wb_we_i && (wb_rd_i == rs2)) begin
                rs2_rdata = wb_data_i;
            end else begin
                rs2_rdata = regs[rs2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Immediate generation
    // ------------------------------------------------------------------
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    logic [XLEN-1:0] dec_imm;

    always_comb begin
        dec_imm = '0;
        if (is_load || is_op_imm || is_op_imm32 || is_jalr) begin
            dec_imm = imm_i;
        end else if (is_store) begin
            dec_imm = imm_s;
        end else if (is_branch) begin
            dec_imm = imm_b;
        end else if (is_lui || is_auipc) begin
            dec_imm = imm_u;
        end else if (is_jal) begin
            dec_imm = imm_j;
        end
    end

    // ------------------------------------------------------------------
    // Load-use hazard detection
    // ------------------------------------------------------------------
    logic uses_rs1;
    logic uses_rs2;
    logic load_use;

    assign uses_rs1 = is_legal & ~(is_lui | is_auipc | is_jal);
    assign uses_rs2 = is_store | is_branch | is_op | is_op32;

    assign load_use = valid_o && mem_read_o && (rd_o != 5'd0) &&
                      ((uses_rs1 && (rd_o == rs1)) || (uses_rs2 && (rd_o == rs2)));

    // A flush discards the dependent instruction anyway, so it cancels the hold.
    assign stall_o = load_use & ~branchtaken;

    // ------------------------------------------------------------------
    // Next decode->execute payload; zero (bubble) unless an instruction issues
    // ------------------------------------------------------------------
    logic issue;
    assign issue = ~branchtaken & ~load_use;

    logic            nxt_valid;
    logic [XLEN-1:0] nxt_pc, nxt_rs1_data, nxt_rs2_data, nxt_imm;
    logic [4:0]      nxt_rs1, nxt_rs2, nxt_rd;
    logic [2:0]      nxt_funct3;
    logic            nxt_funct7b5;
    logic            nxt_reg_we, nxt_mem_read, nxt_mem_write, nxt_branch;
    logic            nxt_jal, nxt_jalr, nxt_alu_src_imm, nxt_lui, nxt_auipc;
    logic            nxt_word_op, nxt_illegal;

    always_comb begin
        nxt_valid       = 1'b0;
        nxt_pc          = '0;
        nxt_rs1_data    = '0;
        nxt_rs2_data    = '0;
        nxt_imm         = '0;
        nxt_rs1         = '0;
        nxt_rs2         = '0;
        nxt_rd          = '0;
        nxt_funct3      = '0;
        nxt_funct7b5    = 1'b0;
        nxt_reg_we      = 1'b0;
        nxt_mem_read    = 1'b0;
        nxt_mem_write   = 1'b0;
        nxt_branch      = 1'b0;
        nxt_jal         = 1'b0;
        nxt_jalr        = 1'b0;
        nxt_alu_src_imm = 1'b0;
        nxt_lui         = 1'b0;
        nxt_auipc       = 1'b0;
        nxt_word_op     = 1'b0;
        nxt_illegal     = 1'b0;
        if (issue) begin
            nxt_valid       = 1'b1;
            nxt_pc          = pc_i;
            nxt_rs1_data    = rs1_rdata;
            nxt_rs2_data    = rs2_rdata;
            nxt_imm         = dec_imm;
            nxt_rs1         = rs1;
            nxt_rs2         = rs2;
            nxt_rd          = rd;
            nxt_funct3      = funct3;
            nxt_funct7b5    = instr[30];
            // Illegal opcodes fall through with every control bit low.
            nxt_reg_we      = is_legal & ~is_store & ~is_branch & (rd != 5'd0);
            nxt_mem_read    = is_load;
            nxt_mem_write   = is_store;
            nxt_branch      = is_branch;
            nxt_jal         = is_jal;
            nxt_jalr        = is_jalr;
            nxt_alu_src_imm = is_load | is_store | is_op_imm | is_op_imm32 | is_jalr;
            nxt_lui         = is_lui;
            nxt_auipc       = is_auipc;
            nxt_word_op     = is_op_imm32 | is_op32;
            nxt_illegal     = ~is_legal;
        end
    end

    // ------------------------------------------------------------------
    // Decode->execute pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_o       <= 1'b0;
            pc_o          <= '0;
            rs1_data_o    <= '0;
            rs2_data_o    <= '0;
            imm_o         <= '0;
            rs1_o         <= '0;
            rs2_o         <= '0;
            rd_o          <= '0;
            funct3_o      <= '0;
            funct7b5_o    <= 1'b0;
            reg_we_o      <= 1'b0;
            mem_read_o    <= 1'b0;
            mem_write_o   <= 1'b0;
            branch_o      <= 1'b0;
            jal_o         <= 1'b0;
            jalr_o        <= 1'b0;
            alu_src_imm_o <= 1'b0;
            lui_o         <= 1'b0;
            auipc_o       <= 1'b0;
            word_op_o     <= 1'b0;
            illegal_o     <= 1'b0;
        end else begin
            valid_o       <= nxt_valid;
            pc_o          <= nxt_pc;
            rs1_data_o    <= nxt_rs1_data;
            rs2_data_o    <= nxt_rs2_data;
            imm_o         <= nxt_imm;
            rs1_o         <= nxt_rs1;
            rs2_o         <= nxt_rs2;
            rd_o          <= nxt_rd;
            funct3_o      <= nxt_funct3;
            funct7b5_o    <= nxt_funct7b5;
            reg_we_o      <= nxt_reg_we;
            mem_read_o    <= nxt_mem_read;
            mem_write_o   <= nxt_mem_write;
            branch_o      <= nxt_branch;
            jal_o         <= nxt_jal;
            jalr_o        <= nxt_jalr;
            alu_src_imm_o <= nxt_alu_src_imm;
            lui_o         <= nxt_lui;
            auipc_o       <= nxt_auipc;
            word_op_o     <= nxt_word_op;
            illegal_o     <= nxt_illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Self-checking bench for decode_stage: a table of single instructions with
// hand-derived immediates and controls, hand-written multi-cycle sequences
// (bypass, load-use stall, flush, reset mid-stall), and a randomized run
// against a behavioural model of the decode stage.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int XLEN = 64;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [31:0]     InstructionMem_out;
    logic [XLEN-1:0] pc_i;
    logic            branchtaken;
    logic            wb_we_i;
    logic [4:0]      wb_rd_i;
    logic [XLEN-1:0] wb_data_i;
    logic            stall_o;
    logic            valid_o;
    logic [XLEN-1:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [4:0]      rs1_o, rs2_o, rd_o;
    logic [2:0]      funct3_o;
    logic            funct7b5_o;
    logic            reg_we_o, mem_read_o, mem_write_o, branch_o, jal_o, jalr_o;
    logic            alu_src_imm_o, lui_o, auipc_o, word_op_o, illegal_o;

    always #5 clk_i = ~clk_i;

    decode_stage #(.XLEN(XLEN), .NREGS(32)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .InstructionMem_out(InstructionMem_out),
        .pc_i(pc_i), .branchtaken(branchtaken), .wb_we_i(wb_we_i),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .stall_o(stall_o),
        .valid_o(valid_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o),
        .rs2_data_o(rs2_data_o), .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .rd_o(rd_o), .funct3_o(funct3_o), .funct7b5_o(funct7b5_o),
        .reg_we_o(reg_we_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o),
        .alu_src_imm_o(alu_src_imm_o), .lui_o(lui_o), .auipc_o(auipc_o),
        .word_op_o(word_op_o), .illegal_o(illegal_o)
    );

    // Control vector bit positions
    localparam int C_WE = 10, C_MR = 9, C_MW = 8, C_BR = 7, C_JAL = 6, C_JALR = 5;
    localparam int C_ALUI = 4, C_LUI = 3, C_AUIPC = 2, C_WORD = 1, C_ILL = 0;

    localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, BRANCH = 7'h63, OPIMM = 7'h13;
    localparam logic [6:0] OP = 7'h33, OPIMM32 = 7'h1B, OP32 = 7'h3B, LUI = 7'h37;
    localparam logic [6:0] AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] rs1d;
        logic [63:0] rs2d;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f7b5;
        logic [10:0] ctrl;
    } out_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] imm;
        logic [10:0] ctrl;
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [63:0] mregs [32];
    out_t        mprev;

    function automatic logic [10:0] dut_ctrl();
        return {reg_we_o, mem_read_o, mem_write_o, branch_o, jal_o, jalr_o,
                alu_src_imm_o, lui_o, auipc_o, word_op_o, illegal_o};
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.valid = valid_o; o.pc = pc_o; o.rs1d = rs1_data_o; o.rs2d = rs2_data_o;
        o.imm = imm_o; o.rs1 = rs1_o; o.rs2 = rs2_o; o.rd = rd_o; o.f3 = funct3_o;
        o.f7b5 = funct7b5_o; o.ctrl = dut_ctrl();
        return o;
    endfunction

    task automatic check_out(input string name, input out_t exp);
        out_t act;
        act = dut_out();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic bt, input logic we,
                         input logic [4:0] rd, input logic [63:0] d, input logic rst);
        InstructionMem_out = ins;
        branchtaken        = bt;
        wb_we_i            = we;
        wb_rd_i            = rd;
        wb_data_i          = d;
        reset_i            = rst;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic logic [63:0] rd_reg(input logic [4:0] r, input logic we,
                                           input logic [4:0] wrd, input logic [63:0] wd);
        if (r == 0) return 64'd0;
        if (we && wrd == r) return wd;
        return mregs[r];
    endfunction

    function automatic out_t model_decode(input logic [31:0] ins, input logic [63:0] pc,
                                          input logic we, input logic [4:0] wrd,
                                          input logic [63:0] wd);
        out_t o;
        longint v;
        logic [6:0] op;
        op = ins[6:0];
        o = '0;
        v = 0;
        o.valid = 1'b1; o.pc = pc;
        o.rs1 = ins[19:15]; o.rs2 = ins[24:20]; o.rd = ins[11:7];
        o.f3 = ins[14:12]; o.f7b5 = ins[30];
        o.rs1d = rd_reg(ins[19:15], we, wrd, wd);
        o.rs2d = rd_reg(ins[24:20], we, wrd, wd);
        // Immediates computed as signed integers from their field weights.
        case (op)
            LOAD, OPIMM, OPIMM32, JALR:
                v = longint'(ins[31:20]) - (ins[31] ? 4096 : 0);
            STORE:
                v = longint'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0);
            BRANCH:
                v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 +
                    longint'(ins[11:8]) * 2 - (ins[31] ? 4096 : 0);
            LUI, AUIPC:
                v = longint'(ins[31:12]) * 4096 - (ins[31] ? 64'sh1_0000_0000 : 64'sd0);
            JAL:
                v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 +
                    longint'(ins[30:21]) * 2 - (ins[31] ? 1048576 : 0);
            default: v = 0;
        endcase
        o.imm = v;
        case (op)
            LOAD:    begin o.ctrl[C_WE] = 1; o.ctrl[C_MR] = 1; o.ctrl[C_ALUI] = 1; end
            STORE:   begin o.ctrl[C_MW] = 1; o.ctrl[C_ALUI] = 1; end
            BRANCH:  o.ctrl[C_BR] = 1;
            OPIMM:   begin o.ctrl[C_WE] = 1; o.ctrl[C_ALUI] = 1; end
            OP:      o.ctrl[C_WE] = 1;
            OPIMM32: begin o.ctrl[C_WE] = 1; o.ctrl[C_ALUI] = 1; o.ctrl[C_WORD] = 1; end
            OP32:    begin o.ctrl[C_WE] = 1; o.ctrl[C_WORD] = 1; end
            LUI:     begin o.ctrl[C_WE] = 1; o.ctrl[C_LUI] = 1; end
            AUIPC:   begin o.ctrl[C_WE] = 1; o.ctrl[C_AUIPC] = 1; end
            JAL:     begin o.ctrl[C_WE] = 1; o.ctrl[C_JAL] = 1; end
            JALR:    begin o.ctrl[C_WE] = 1; o.ctrl[C_JALR] = 1; o.ctrl[C_ALUI] = 1; end
            default: o.ctrl[C_ILL] = 1;
        endcase
        if (ins[11:7] == 5'd0) o.ctrl[C_WE] = 1'b0;
        return o;
    endfunction

    function automatic logic model_stall(input logic [31:0] ins, input logic bt);
        logic [6:0] op;
        logic r1, r2;
        op = ins[6:0];
        r1 = op inside {LOAD, STORE, BRANCH, OPIMM, OP, OPIMM32, OP32, JALR};
        r2 = op inside {STORE, BRANCH, OP, OP32};
        return !bt && mprev.valid && mprev.ctrl[C_MR] && (mprev.rd != 5'd0) &&
               ((r1 && mprev.rd == ins[19:15]) || (r2 && mprev.rd == ins[24:20]));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [13];
        logic [31:0] ins;
        ops = '{LOAD, STORE, BRANCH, OPIMM, OP, OPIMM32, OP32, LUI, AUIPC, JAL, JALR,
                7'h7F, 7'h0F};
        ins        = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 12)];
        ins[11:7]  = 5'($urandom_range(0, 5));
        ins[19:15] = 5'($urandom_range(0, 5));
        ins[24:20] = 5'($urandom_range(0, 5));
        return ins;
    endfunction

    // ---------------- stimulus ----------------
    vec_t tbl [12];

    initial begin
        out_t        exp;
        logic [31:0] ins;
        logic [63:0] pc;
        logic        bt, we, rst, st, hold;
        logic [4:0]  wrd;
        logic [63:0] wd;

        tbl[0]  = '{32'h00500093, 64'd5,                    11'b10000010000}; // addi x1,x0,5
        tbl[1]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 11'b00010000000}; // beq -4
        tbl[2]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 11'b10000001000}; // lui
        tbl[3]  = '{32'hFFFFFFFF, 64'd0,                    11'b00000000001}; // illegal
        tbl[4]  = '{32'h0000B183, 64'd0,                    11'b11000010000}; // ld x3,0(x1)
        tbl[5]  = '{32'hFE20AC23, 64'hFFFF_FFFF_FFFF_FFF8, 11'b00100010000}; // sw x2,-8(x1)
        tbl[6]  = '{32'h008000EF, 64'd8,                    11'b10001000000}; // jal x1,8
        tbl[7]  = '{32'h00008067, 64'd0,                    11'b00000110000}; // jalr x0,0(x1)
        tbl[8]  = '{32'h12345297, 64'h0000_0000_1234_5000, 11'b10000000100}; // auipc x5
        tbl[9]  = '{32'hFFF0809B, 64'hFFFF_FFFF_FFFF_FFFF, 11'b10000010010}; // addiw x1,x1,-1
        tbl[10] = '{32'h402081BB, 64'd0,                    11'b10000000010}; // subw x3,x1,x2
        tbl[11] = '{32'h00318233, 64'd0,                    11'b10000000000}; // add x4,x3,x3

        pc_i = 64'h1000;
        drive(32'h00000013, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1);
        tick();
        check_out("reset_state", out_t'(0));
        check_val("reset_stall", {63'd0, stall_o}, 64'd0);
        drive(32'h00000013, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);

        // Table: each vector is preceded by a flush cycle so no hazard carries over.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].ins, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0);
            tick();
            drive(tbl[i].ins, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
            #1;
            check_val($sformatf("tbl%0d_stall", i), {63'd0, stall_o}, 64'd0);
            tick();
            check_val($sformatf("tbl%0d_decode", i),
                      {valid_o, imm_o[51:0], dut_ctrl()},
                      {1'b1, tbl[i].imm[51:0], tbl[i].ctrl});
            check_val($sformatf("tbl%0d_imm_hi", i), {52'd0, imm_o[63:52]},
                      {52'd0, tbl[i].imm[63:52]});
        end

        // Writeback bypass into rs1, then x0 write ignored.
        drive(32'h00018113, 1'b0, 1'b1, 5'd3, 64'hAA, 1'b0);
        tick();
        check_val("bypass_rs1", rs1_data_o, 64'hAA);
        drive(32'h00000113, 1'b0, 1'b1, 5'd0, 64'h55, 1'b0);
        tick();
        check_val("x0_bypass", rs1_data_o, 64'd0);
        drive(32'h00000113, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
        tick();
        check_val("x0_stays0", rs1_data_o, 64'd0);
        drive(32'h00018113, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
        tick();
        check_val("x3_written", rs1_data_o, 64'hAA);

        // Load-use: one stall cycle, one bubble, then the add issues.
        drive(32'h0000B183, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
        tick();
        drive(32'h00318233, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
        #1;
        check_val("lu_stall", {63'd0, stall_o}, 64'd1);
        tick();
        check_val("lu_bubble", {valid_o, dut_ctrl(), rd_o, imm_o}, '0);
        check_val("lu_stall_clear", {63'd0, stall_o}, 64'd0);
        tick();
        check_val("lu_issue", {valid_o, rs1_o, rs2_o, rd_o, reg_we_o},
                  {1'b1, 5'd3, 5'd3, 5'd4, 1'b1});

        // Flush coincident with load-use.
        drive(32'h0000B183, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
        tick();
        drive(32'h00318233, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0);
        #1;
        check_val("flush_stall", {63'd0, stall_o}, 64'd0);
        tick();
        check_val("flush_bubble", {valid_o, dut_ctrl()}, '0);

        // Reset during a stall, then register file must be cleared.
        drive(32'h0000B183, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
        tick();
        drive(32'h00318233, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1);
        #1;
        check_val("rst_pre_stall", {63'd0, stall_o}, 64'd1);
        tick();
        check_out("rst_mid_stall", out_t'(0));
        check_val("rst_stall_after", {63'd0, stall_o}, 64'd0);
        drive(32'h00018113, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
        tick();
        check_val("rst_regs_clear", rs1_data_o, 64'd0);

        // Randomized run against the model, starting from a fresh reset.
        drive(32'h00000013, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1);
        tick();
        for (int r = 0; r < 32; r++) mregs[r] = 64'd0;
        mprev = '0;
        hold = 1'b0;
        ins = 32'h00000013;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) ins = rand_instr();
            pc  = {$urandom, $urandom};
            bt  = ($urandom_range(0, 9) == 0);
            we  = 1'($urandom_range(0, 1));
            wrd = 5'($urandom_range(0, 6));
            wd  = {$urandom, $urandom};
            rst = ($urandom_range(0, 99) == 0);
            pc_i = pc;
            drive(ins, bt, we, wrd, wd, rst);
            #1;
            st = model_stall(ins, bt);
            check_val("rand_stall", {63'd0, stall_o}, {63'd0, st});
            if (rst || bt || st) exp = '0;
            else exp = model_decode(ins, pc, we, wrd, wd);
            tick();
            check_out("rand_out", exp);
            if (rst) begin
                for (int r = 0; r < 32; r++) mregs[r] = 64'd0;
            end else if (we && wrd != 5'd0) begin
                mregs[wrd] = wd;
            end
            mprev = exp;
            hold = st;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
